execute_stage: RTL

//  EX stage of the 5-stage RV32I pipeline; consumes the ID/EX register outputs of the decode stage.

---
 rtl/rv_pkg.sv | 49 ++++
 rtl/execute_stage_if.sv | 50 +++++
 rtl/exec_alu.sv | 49 ++++
 rtl/execute_stage.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I encodings for the EX stage: ALU op codes, branch funct3 values,
// operand-A source and forwarding selects.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ   = 3'b000,
    BR_NE   = 3'b001,
    BR_JAL  = 3'b010,
    BR_JALR = 3'b011,
    BR_LT   = 3'b100,
    BR_GE   = 3'b101,
    BR_LTU  = 3'b110,
    BR_GEU  = 3'b111
  } br_f3_e;

  typedef enum logic [1:0] {
    SRCA_R1   = 2'b00,
    SRCA_PC   = 2'b01,
    SRCA_ZERO = 2'b10
  } srca_e;

  // Encoding 2'b11 is not produced by the hazard unit and falls back to the regfile.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  function automatic logic is_jump(input logic [2:0] f3);
    return (f3 == BR_JAL) || (f3 == BR_JALR);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, forwarding and redirect/EX-MEM outputs of the execute stage.
// master = decode/hazard/memory side, slave = the execute stage itself.
interface execute_stage_if #(parameter int XLEN = rv_pkg::XLEN_DEFAULT);

  logic            validE;
  logic            stallM;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            MemtoRegE;
  logic            PCBranchE;
  logic            SrcBSelE;
  logic [1:0]      SrcASelE;
  logic [3:0]      ALUopE;
  logic [2:0]      strCtrlE;
  logic [XLEN-1:0] r1E;
  logic [XLEN-1:0] r2E;
  logic [XLEN-1:0] immE;
  logic [XLEN-1:0] PCE;
  logic [4:0]      rdE;
  logic [1:0]      fwdAE;
  logic [1:0]      fwdBE;
  logic [XLEN-1:0] resultW;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            validM;
  logic            RegWriteM;
  logic            MemWriteM;
  logic            MemtoRegM;
  logic [2:0]      strCtrlM;
  logic [4:0]      rdM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCplus4M;

  modport master (
    output validE, stallM, RegWriteE, MemWriteE, MemtoRegE, PCBranchE, SrcBSelE,
           SrcASelE, ALUopE, strCtrlE, r1E, r2E, immE, PCE, rdE, fwdAE, fwdBE, resultW,
    input  PCSrcE, PCTargetE, validM, RegWriteM, MemWriteM, MemtoRegM, strCtrlM, rdM,
           ALUResultM, WriteDataM, PCplus4M
  );

  modport slave (
    input  validE, stallM, RegWriteE, MemWriteE, MemtoRegE, PCBranchE, SrcBSelE,
           SrcASelE, ALUopE, strCtrlE, r1E, r2E, immE, PCE, rdE, fwdAE, fwdBE, resultW,
    output PCSrcE, PCTargetE, validM, RegWriteM, MemWriteM, MemtoRegM, strCtrlM, rdM,
           ALUResultM, WriteDataM, PCplus4M
  );

endinterface

// File: rtl/exec_alu.sv
// Combinational ALU plus equality / signed / unsigned comparison flags used
// for branch resolution on a separate operand pair.
module exec_alu
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] cmp_a_i,
  input  logic [XLEN-1:0] cmp_b_i,
  output logic [XLEN-1:0] result_o,
  output logic            eq_o,
  output logic            lt_o,
  output logic            ltu_o
);

  logic [4:0] shamt;
  logic       slt;
  logic       sltu;

  assign shamt = b_i[4:0];
  assign slt   = $signed(a_i) < $signed(b_i);
  assign sltu  = a_i < b_i;

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, slt};
      ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, sltu};
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = $signed(a_i) >>> shamt;
      ALU_OR:    result_o = a_i | b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end

  assign eq_o  = cmp_a_i == cmp_b_i;
  assign lt_o  = $signed(cmp_a_i) < $signed(cmp_b_i);
  assign ltu_o = cmp_a_i < cmp_b_i;

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution with a
// single-cycle fetch redirect, and the EX/MEM pipeline register.
module execute_stage
  import rv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave ex
);

  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b;
  logic [XLEN-1:0] alu_result, pc_plus4, target_sum;
  logic            eq, lt, ltu, taken, jalr_sel, jump_sel;

  logic            valid_q, valid_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_write_q, mem_write_d;
  logic            mem_to_reg_q, mem_to_reg_d;
  logic [2:0]      str_ctrl_q, str_ctrl_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  // M-stage forwarding uses the registered result, never the current ALU output.
  always_comb begin
    fwd_a = ex.r1E;
    case (ex.fwdAE)
      FWD_W:   fwd_a = ex.resultW;
      FWD_M:   fwd_a = alu_result_q;
      default: fwd_a = ex.r1E;
    endcase
    fwd_b = ex.r2E;
    case (ex.fwdBE)
      FWD_W:   fwd_b = ex.resultW;
      FWD_M:   fwd_b = alu_result_q;
      default: fwd_b = ex.r2E;
    endcase
  end

  always_comb begin
    src_a = fwd_a;
    case (ex.SrcASelE)
      SRCA_PC:   src_a = ex.PCE;
      SRCA_ZERO: src_a = '0;
      default:   src_a = fwd_a;
    endcase
  end

  assign src_b = ex.SrcBSelE ? ex.immE : fwd_b;

  exec_alu #(.XLEN(XLEN)) u_alu (
    .a_i      (src_a),
    .b_i      (src_b),
    .op_i     (ex.ALUopE),
    .cmp_a_i  (fwd_a),
    .cmp_b_i  (fwd_b),
    .result_o (alu_result),
    .eq_o     (eq),
    .lt_o     (lt),
    .ltu_o    (ltu)
  );

  always_comb begin
    taken = 1'b0;
    case (ex.strCtrlE)
      BR_EQ:   taken = eq;
      BR_NE:   taken = ~eq;
      BR_LT:   taken = lt;
      BR_GE:   taken = ~lt;
      BR_LTU:  taken = ltu;
      BR_GEU:  taken = ~ltu;
      BR_JAL:  taken = 1'b1;
      BR_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sel   = ex.PCBranchE && (ex.strCtrlE == BR_JALR);
  assign jump_sel   = ex.PCBranchE && is_jump(ex.strCtrlE);
  assign target_sum = (jalr_sel ? fwd_a : ex.PCE) + ex.immE;
  assign pc_plus4   = ex.PCE + XLEN'(4);

  assign ex.PCTargetE = {target_sum[XLEN-1:1], target_sum[0] & ~jalr_sel};
  // A held or resetting instruction must not redirect; it fires once it leaves EX.
  assign ex.PCSrcE    = ex.validE & ex.PCBranchE & taken & ~ex.stallM & ~rst;

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    str_ctrl_d   = str_ctrl_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    if (!ex.stallM) begin
      if (ex.validE) begin
        valid_d      = 1'b1;
        reg_write_d  = ex.RegWriteE;
        mem_write_d  = ex.MemWriteE;
        mem_to_reg_d = ex.MemtoRegE;
        str_ctrl_d   = ex.strCtrlE;
        rd_d         = ex.rdE;
        alu_result_d = jump_sel ? pc_plus4 : alu_result;
        write_data_d = fwd_b;
        pc_plus4_d   = pc_plus4;
      end else begin
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        str_ctrl_d   = '0;
        rd_d         = '0;
        alu_result_d = '0;
        write_data_d = '0;
        pc_plus4_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      str_ctrl_q   <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= RESET_PC;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      str_ctrl_q   <= str_ctrl_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign ex.validM     = valid_q;
  assign ex.RegWriteM  = reg_write_q;
  assign ex.MemWriteM  = mem_write_q;
  assign ex.MemtoRegM  = mem_to_reg_q;
  assign ex.strCtrlM   = str_ctrl_q;
  assign ex.rdM        = rd_q;
  assign ex.ALUResultM = alu_result_q;
  assign ex.WriteDataM = write_data_q;
  assign ex.PCplus4M   = pc_plus4_q;

endmodule
